// File: rtl/vm_pkg.sv
// Shared definitions for the multi-product vending controller: FSM encoding,
// coin bit positions and coin values in 50-unit steps.
package vm_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StVend   = 2'b01,
    StChange = 2'b10
  } vm_state_e;

  localparam int unsigned CoinBit50  = 0;
  localparam int unsigned CoinBit100 = 1;
  localparam int unsigned CoinBit500 = 2;

  localparam int unsigned CoinVal50  = 1;
  localparam int unsigned CoinVal100 = 2;
  localparam int unsigned CoinVal500 = 10;

  // Value of a one-hot coin strobe; multi-hot vectors are filtered before use.
  function automatic int unsigned coin_value(logic [2:0] coin);
    int unsigned val;
    val = 0;
    if (coin[CoinBit50])  val = CoinVal50;
    if (coin[CoinBit100]) val = CoinVal100;
    if (coin[CoinBit500]) val = CoinVal500;
    return val;
  endfunction

endpackage

// File: rtl/vm_change_disp.sv
// Change dispenser: counts a loaded credit down, one coin per cycle, preferring
// 100 coins and finishing with a single 50 coin on odd amounts.
module vm_change_disp #(
  parameter int unsigned CREDIT_W = 6
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load_i,
  input  logic [CREDIT_W-1:0] load_credit_i,
  output logic                chg_100_o,
  output logic                chg_050_o,
  output logic                done_o,
  output logic [CREDIT_W-1:0] rem_o
);

  logic [CREDIT_W-1:0] rem_q, rem_d;
  logic                chg_100_q, chg_100_d;
  logic                chg_050_q, chg_050_d;

  always_comb begin
    rem_d     = rem_q;
    chg_100_d = 1'b0;
    chg_050_d = 1'b0;
    if (rem_q >= CREDIT_W'(2)) begin
      rem_d     = rem_q - CREDIT_W'(2);
      chg_100_d = 1'b1;
    end else if (rem_q == CREDIT_W'(1)) begin
      rem_d     = '0;
      chg_050_d = 1'b1;
    end
  end

  // done marks the cycle whose step empties the counter
  assign done_o    = (rem_q != '0) && (rem_d == '0);
  assign rem_o     = rem_d;
  assign chg_100_o = chg_100_q;
  assign chg_050_o = chg_050_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rem_q     <= '0;
      chg_100_q <= 1'b0;
      chg_050_q <= 1'b0;
    end else begin
      rem_q     <= load_i ? load_credit_i : rem_d;
      chg_100_q <= chg_100_d;
      chg_050_q <= chg_050_d;
    end
  end

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: event decode, price mux, credit register and FSM.
// Define VM_AUTO_CHANGE_EN to pay out leftover credit automatically after every sale.
module vending_machine_multi
  import vm_pkg::*;
#(
  parameter int unsigned          N_PROD     = 4,
  parameter int unsigned          CREDIT_W   = 6,
  parameter int unsigned          MAX_CREDIT = 40,
  parameter logic [8*N_PROD-1:0]  PRICES     = {8'd6, 8'd4, 8'd3, 8'd2}
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [2:0]          coin_i,
  input  logic [N_PROD-1:0]   sel_i,
  input  logic                ret_i,
  input  logic [N_PROD-1:0]   empty_i,
  output logic [N_PROD-1:0]   vend_o,
  output logic                chg_100_o,
  output logic                chg_050_o,
  output logic                coin_rej_o,
  output logic                deny_o,
  output logic                busy_o,
  output logic [CREDIT_W-1:0] credit_o
);

  localparam int unsigned IdxW = (N_PROD > 1) ? $clog2(N_PROD) : 1;
  localparam int unsigned CmpW = (CREDIT_W > 8) ? CREDIT_W : 8;

  vm_state_e           state_q;
  logic [CREDIT_W-1:0] credit_q;
  logic [IdxW-1:0]     idx_q;
  logic [N_PROD-1:0]   vend_q;
  logic                coin_rej_q, deny_q, busy_q;

  logic                ev_valid, is_coin, is_sel, is_ret;
  logic [IdxW-1:0]     sel_idx;
  logic [7:0]          sel_price, cur_price;
  logic [N_PROD-1:0]   vend_onehot;
  logic [CREDIT_W:0]   credit_sum;
  logic                coin_fits, afford, sel_empty;
  logic [CREDIT_W-1:0] vend_rem;
  logic                chg_load, chg_done;
  logic [CREDIT_W-1:0] chg_load_val, chg_rem;

  // Exactly one of {ret, sel, coin} set is an event; anything else is dropped.
  always_comb begin
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < 3; i++) cnt += 32'(coin_i[i]);
    for (int i = 0; i < int'(N_PROD); i++) cnt += 32'(sel_i[i]);
    cnt += 32'(ret_i);
    ev_valid = (cnt == 1);
    is_coin  = ev_valid && (coin_i != '0);
    is_sel   = ev_valid && (sel_i != '0);
    is_ret   = ev_valid && ret_i;
  end

  always_comb begin
    sel_idx     = '0;
    sel_price   = '0;
    cur_price   = '0;
    vend_onehot = '0;
    for (int i = 0; i < int'(N_PROD); i++) begin
      if (sel_i[i]) sel_idx = IdxW'(i);
    end
    for (int i = 0; i < int'(N_PROD); i++) begin
      if (sel_idx == IdxW'(i)) sel_price = PRICES[8*i +: 8];
      if (idx_q == IdxW'(i)) begin
        cur_price      = PRICES[8*i +: 8];
        vend_onehot[i] = 1'b1;
      end
    end
  end

  assign credit_sum = {1'b0, credit_q} + (CREDIT_W+1)'(coin_value(coin_i));
  assign coin_fits  = credit_sum <= (CREDIT_W+1)'(MAX_CREDIT);
  assign afford     = CmpW'(credit_q) >= CmpW'(sel_price);
  assign sel_empty  = |(sel_i & empty_i);
  assign vend_rem   = credit_q - CREDIT_W'(cur_price);

  always_comb begin
    chg_load     = (state_q == StIdle) && is_ret && (credit_q != '0);
    chg_load_val = credit_q;
`ifdef VM_AUTO_CHANGE_EN
    if (state_q == StVend) begin
      chg_load     = (vend_rem != '0);
      chg_load_val = vend_rem;
    end
`endif
  end

  vm_change_disp #(
    .CREDIT_W (CREDIT_W)
  ) u_change_disp (
    .clock         (clock),
    .reset         (reset),
    .load_i        (chg_load),
    .load_credit_i (chg_load_val),
    .chg_100_o     (chg_100_o),
    .chg_050_o     (chg_050_o),
    .done_o        (chg_done),
    .rem_o         (chg_rem)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      credit_q   <= '0;
      idx_q      <= '0;
      vend_q     <= '0;
      coin_rej_q <= 1'b0;
      deny_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      vend_q     <= '0;
      coin_rej_q <= 1'b0;
      deny_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (is_coin) begin
            if (coin_fits) credit_q <= credit_sum[CREDIT_W-1:0];
            else           coin_rej_q <= 1'b1;
          end else if (is_sel) begin
            if (sel_empty || !afford) begin
              deny_q <= 1'b1;
            end else begin
              idx_q   <= sel_idx;
              state_q <= StVend;
              busy_q  <= 1'b1;
            end
          end else if (is_ret && (credit_q != '0)) begin
            state_q <= StChange;
            busy_q  <= 1'b1;
          end
        end
        StVend: begin
          coin_rej_q <= is_coin;
          vend_q     <= vend_onehot;
          credit_q   <= vend_rem;
`ifdef VM_AUTO_CHANGE_EN
          if (vend_rem != '0) begin
            state_q <= StChange;
            busy_q  <= 1'b1;
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
`else
          state_q <= StIdle;
          busy_q  <= 1'b0;
`endif
        end
        StChange: begin
          coin_rej_q <= is_coin;
          credit_q   <= chg_rem;
          if (chg_done) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign vend_o     = vend_q;
  assign coin_rej_o = coin_rej_q;
  assign deny_o     = deny_q;
  assign busy_o     = busy_q;
  assign credit_o   = credit_q;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Directed bench for vending_machine_multi; expectations follow VM_AUTO_CHANGE_EN.
module tb_vending_machine_multi;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] coin  = '0;
  logic [3:0] sel   = '0;
  logic       ret   = 1'b0;
  logic [3:0] empty = '0;
  logic [3:0] vend;
  logic       chg_100, chg_050, coin_rej, deny, busy;
  logic [5:0] credit;

  int vectors     = 0;
  int miscompares = 0;

  vending_machine_multi u_dut (
    .clock      (clock),
    .reset      (reset),
    .coin_i     (coin),
    .sel_i      (sel),
    .ret_i      (ret),
    .empty_i    (empty),
    .vend_o     (vend),
    .chg_100_o  (chg_100),
    .chg_050_o  (chg_050),
    .coin_rej_o (coin_rej),
    .deny_o     (deny),
    .busy_o     (busy),
    .credit_o   (credit)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one strobe for one cycle; returns 1 ns after the sampling edge.
  task automatic apply(input logic [2:0] c, input logic [3:0] s, input logic r);
    coin = c;
    sel  = s;
    ret  = r;
    tick();
    coin = '0;
    sel  = '0;
    ret  = 1'b0;
  endtask

  initial begin
    // Reset values
    #12;
    chk("rst_credit", credit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_vend", vend, 0);
    chk("rst_pulses", {chg_100, chg_050, coin_rej, deny}, 0);
    tick();
    reset = 1'b1;

    // T1: 100, 100, 50 then product 2 (price 4)
    apply(3'b010, 4'b0000, 1'b0);
    chk("t1_credit_a", credit, 2);
    apply(3'b010, 4'b0000, 1'b0);
    chk("t1_credit_b", credit, 4);
    apply(3'b001, 4'b0000, 1'b0);
    chk("t1_credit_c", credit, 5);
    apply(3'b000, 4'b0100, 1'b0);
    chk("t1_decide_busy", busy, 1);
    chk("t1_decide_vend", vend, 0);
    tick();
    chk("t1_vend", vend, 4'b0100);
    chk("t1_credit_after_vend", credit, 1);
`ifdef VM_AUTO_CHANGE_EN
    chk("t1_busy_after_vend", busy, 1);
    tick();
`else
    chk("t1_busy_after_vend", busy, 0);
    tick();
    chk("t1_kept_credit", credit, 1);
    chk("t1_no_change", {chg_100, chg_050}, 0);
    apply(3'b000, 4'b0000, 1'b1);
    chk("t1_ret_busy", busy, 1);
    tick();
`endif
    chk("t1_chg050", {chg_100, chg_050}, 2'b01);
    chk("t1_credit_zero", credit, 0);
    chk("t1_busy_drop", busy, 0);

    // T2: fill to the ceiling, over-ceiling coin, then 20 x 100 change
    for (int i = 1; i <= 4; i++) begin
      apply(3'b100, 4'b0000, 1'b0);
      chk("t2_fill", credit, 10 * i);
    end
    apply(3'b001, 4'b0000, 1'b0);
    chk("t2_rej", coin_rej, 1);
    chk("t2_credit_held", credit, 40);
    apply(3'b000, 4'b0000, 1'b1);
    chk("t2_ret_busy", busy, 1);
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk("t2_chg100", {chg_100, chg_050}, 2'b10);
      chk("t2_credit_step", credit, 40 - 2 * i);
    end
    chk("t2_busy_drop", busy, 0);
    tick();
    chk("t2_pulses_end", {chg_100, chg_050}, 0);

    // T3: insufficient credit, then sold-out product
    apply(3'b010, 4'b0000, 1'b0);
    apply(3'b001, 4'b0000, 1'b0);
    chk("t3_credit", credit, 3);
    apply(3'b000, 4'b1000, 1'b0);
    chk("t3_deny_price", deny, 1);
    chk("t3_credit_held", credit, 3);
    chk("t3_not_busy", busy, 0);
    empty = 4'b0001;
    apply(3'b000, 4'b0001, 1'b0);
    chk("t3_deny_empty", deny, 1);
    chk("t3_not_busy_b", busy, 0);
    empty = 4'b0000;

    // T4: multi-hot vectors are ignored entirely
    apply(3'b011, 4'b0000, 1'b0);
    chk("t4_coin_multi", {coin_rej, deny, busy}, 0);
    chk("t4_credit_a", credit, 3);
    apply(3'b000, 4'b0001, 1'b1);
    chk("t4_sel_ret", {coin_rej, deny, busy, vend}, 0);
    tick();
    chk("t4_credit_b", credit, 3);
    chk("t4_quiet", {busy, vend, chg_100, chg_050}, 0);

    // T5: payout of 7 with a coin and a select during it
    apply(3'b010, 4'b0000, 1'b0);
    apply(3'b010, 4'b0000, 1'b0);
    chk("t5_credit", credit, 7);
    apply(3'b000, 4'b0000, 1'b1);
    chk("t5_busy", busy, 1);
    apply(3'b010, 4'b0000, 1'b0);
    chk("t5_c1", {chg_100, chg_050}, 2'b10);
    chk("t5_coin_rej", coin_rej, 1);
    chk("t5_credit_c1", credit, 5);
    apply(3'b000, 4'b0001, 1'b0);
    chk("t5_c2", {chg_100, chg_050}, 2'b10);
    chk("t5_sel_ignored", {deny, vend, coin_rej}, 0);
    chk("t5_credit_c2", credit, 3);
    tick();
    chk("t5_c3", {chg_100, chg_050}, 2'b10);
    chk("t5_credit_c3", credit, 1);
    tick();
    chk("t5_c4", {chg_100, chg_050}, 2'b01);
    chk("t5_credit_c4", credit, 0);
    chk("t5_busy_drop", busy, 0);
    tick();
    chk("t5_after", {vend, chg_100, chg_050, busy}, 0);

    // T6: reset during the second change cycle
    apply(3'b010, 4'b0000, 1'b0);
    apply(3'b010, 4'b0000, 1'b0);
    apply(3'b000, 4'b0000, 1'b1);
    tick();
    chk("t6_first_coin", {chg_100, credit}, {1'b1, 6'd2});
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_clear", {vend, chg_100, chg_050, coin_rej, deny, busy, credit}, 0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    chk("t6_after_reset", {chg_100, chg_050, busy, credit}, 0);

    // T6b: sale with leftover credit
    apply(3'b010, 4'b0000, 1'b0);
    apply(3'b010, 4'b0000, 1'b0);
    apply(3'b001, 4'b0000, 1'b0);
    apply(3'b000, 4'b0001, 1'b0);
    tick();
    chk("t6b_vend", vend, 4'b0001);
    chk("t6b_credit", credit, 3);
`ifdef VM_AUTO_CHANGE_EN
    tick();
    chk("t6b_chg_a", {chg_100, chg_050, credit}, {2'b10, 6'd1});
    tick();
    chk("t6b_chg_b", {chg_100, chg_050, credit}, {2'b01, 6'd0});
`else
    chk("t6b_busy", busy, 0);
    tick();
    chk("t6b_no_change", {chg_100, chg_050, vend}, 0);
    chk("t6b_credit_kept", credit, 3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
